vga_timing_gen: RTL and testbench

- Video timing generator clocked by the 148.5 MHz pixel clock from the VGA clock wizard.
- Produces hsync, vsync, data-enable, pixel coordinates and a frame-start strobe for 1920x1080@60.
- Counting is gated by the wizard's locked output, so no timing leaves the block until the pixel clock is stable.
- Feeds the downstream pattern/pixel source and the video output encoder.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for a progressive video mode (default 1920x1080@60
//   on a 148.5 MHz pixel clock). Horizontal and vertical counters walk the
//   line/frame with the active region first, then front porch, sync, back porch.
//   Every output is a registered decode of the counter values from the previous
//   cycle. While rst is high or the pixel PLL is unlocked, the counters are held
//   at zero and the outputs are held inactive. The first locked cycle therefore
//   always starts a fresh frame at pixel (0,0).
//
// Ports
//   clk         in   pixel clock
//   rst         in   synchronous reset, active-high (has priority over locked)
//   locked      in   PLL lock, used as the count enable (synchronous to clk)
//   hsync       out  horizontal sync, active level HS_POL
//   vsync       out  vertical sync, active level VS_POL (changes only at line start)
//   de          out  active-video data enable
//   pix_x[11:0] out  active column, 0 when de=0
//   pix_y[10:0] out  active row, 0 when de=0
//   frame_start out  one-cycle pulse coinciding with pixel (0,0)
//
// Supported parameter sets are those with H_TOTAL <= 4096 and V_TOTAL <= 2048.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] LP_H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] LP_HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] LP_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] LP_H_LAST = 12'(H_TOTAL - 1);

  localparam logic [10:0] LP_V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] LP_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] LP_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] LP_V_LAST = 11'(V_TOTAL - 1);

  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [11:0] r_pix_x;
  logic [10:0] r_pix_y;
  logic        r_frame_start;

  logic [11:0] w_h_nxt;
  logic [10:0] w_v_nxt;
  logic        w_de;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_frame_start;

  always_comb begin
    w_h_nxt = r_h_cnt + 12'd1;
    w_v_nxt = r_v_cnt;
    if (r_h_cnt == LP_H_LAST) begin
      w_h_nxt = '0;
      if (r_v_cnt == LP_V_LAST) begin
        w_v_nxt = '0;
      end else begin
        w_v_nxt = r_v_cnt + 11'd1;
      end
    end
  end

  always_comb begin
    w_de          = (r_h_cnt < LP_H_ACT) && (r_v_cnt < LP_V_ACT);
    w_hs_act      = (r_h_cnt >= LP_HS_BEG) && (r_h_cnt <= LP_HS_END);
    // v_cnt only moves on the h wrap, so vsync can only change at a line start.
    w_vs_act      = (r_v_cnt >= LP_VS_BEG) && (r_v_cnt <= LP_VS_END);
    w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Unlocked is the same hold state as reset, so re-lock restarts at (0,0)
  // instead of resuming a partial frame.
  always_ff @(posedge clk) begin
    if (rst || !locked) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_hsync       <= !HS_POL;
      r_vsync       <= !VS_POL;
      r_de          <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_hsync       <= w_hs_act ? HS_POL : !HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : !VS_POL;
      r_de          <= w_de;
      r_pix_x       <= w_de ? r_h_cnt : '0;
      r_pix_y       <= w_de ? r_v_cnt : '0;
      r_frame_start <= w_frame_start;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one default-parameter instance for the
// line/lock/reset behaviour, and one small-parameter instance with inverted
// sync polarity for whole-frame behaviour.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        locked_a;
  logic        locked_b;

  logic        hs_a, vs_a, de_a, fs_a;
  logic [11:0] px_a;
  logic [10:0] py_a;

  logic        hs_b, vs_b, de_b, fs_b;
  logic [11:0] px_b;
  logic [10:0] py_b;

  int n_checks;
  int n_fail;

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .de          (de_a),
    .pix_x       (px_a),
    .pix_y       (py_a),
    .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b0),
    .VS_POL   (1'b0)
  ) u_dut_small (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .de          (de_b),
    .pix_x       (px_b),
    .pix_y       (py_b),
    .frame_start (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int de_n, hs_n, hs_first, pix_err, fs_extra, vs_err, glitch;
    int fs_n, fs_first, fs_second, hsl_n, hsl_first, vsl_n, vsl_first;
    int max_x, max_y, vs_mid;
    logic prev_vs;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    locked_a = 1'b1;
    locked_b = 1'b0;

    // Reset with lock present
    repeat (5) tick();
    check_eq("rst_de",    32'(de_a), 0);
    check_eq("rst_fs",    32'(fs_a), 0);
    check_eq("rst_pix_x", 32'(px_a), 0);
    check_eq("rst_pix_y", 32'(py_a), 0);
    check_eq("rst_hsync", 32'(hs_a), 0);
    check_eq("rst_vsync", 32'(vs_a), 0);
    check_eq("rst_small_hsync", 32'(hs_b), 1);
    check_eq("rst_small_vsync", 32'(vs_b), 1);
    rst = 1'b0;

    // First line after reset release
    de_n = 0; hs_n = 0; hs_first = -1; pix_err = 0; fs_extra = 0; vs_err = 0;
    for (int k = 0; k < 2200; k++) begin
      tick();
      if (k == 0) begin
        check_eq("first_fs",    32'(fs_a), 1);
        check_eq("first_de",    32'(de_a), 1);
        check_eq("first_pix_x", 32'(px_a), 0);
        check_eq("first_pix_y", 32'(py_a), 0);
      end
      if (de_a) de_n++;
      if (de_a && (32'(px_a) != k)) pix_err++;
      if (!de_a && (px_a != 12'd0)) pix_err++;
      if (py_a != 11'd0) pix_err++;
      if (hs_a) begin
        hs_n++;
        if (hs_first < 0) hs_first = k;
      end
      if (fs_a && k != 0) fs_extra++;
      if (vs_a) vs_err++;
    end
    check_eq("line_de_count",    32'(de_n), 1920);
    check_eq("line_hsync_count", 32'(hs_n), 44);
    check_eq("line_hsync_start", 32'(hs_first), 2008);
    check_eq("line_pix_errors",  32'(pix_err), 0);
    check_eq("line_fs_extra",    32'(fs_extra), 0);
    check_eq("line_vsync_high",  32'(vs_err), 0);

    tick();
    check_eq("line1_de",    32'(de_a), 1);
    check_eq("line1_pix_x", 32'(px_a), 0);
    check_eq("line1_pix_y", 32'(py_a), 1);
    check_eq("line1_fs",    32'(fs_a), 0);

    // Lock drop at pixel (500,2)
    repeat (2700) tick();
    check_eq("pre_drop_pix_x", 32'(px_a), 500);
    check_eq("pre_drop_pix_y", 32'(py_a), 2);
    locked_a = 1'b0;
    tick();
    check_eq("drop_de",    32'(de_a), 0);
    check_eq("drop_hsync", 32'(hs_a), 0);
    check_eq("drop_vsync", 32'(vs_a), 0);
    check_eq("drop_pix_x", 32'(px_a), 0);
    check_eq("drop_fs",    32'(fs_a), 0);
    repeat (9) tick();
    locked_a = 1'b1;
    tick();
    check_eq("relock_fs",    32'(fs_a), 1);
    check_eq("relock_pix_x", 32'(px_a), 0);
    check_eq("relock_pix_y", 32'(py_a), 0);
    check_eq("relock_de",    32'(de_a), 1);
    tick();
    check_eq("relock_next_pix_x", 32'(px_a), 1);
    check_eq("relock_next_fs",    32'(fs_a), 0);

    // rst and locked=0 together while hsync is active, then release together
    repeat (2019) tick();
    check_eq("pre_rst_hsync", 32'(hs_a), 1);
    rst      = 1'b1;
    locked_a = 1'b0;
    glitch   = 0;
    repeat (4) begin
      tick();
      if (hs_a || vs_a || de_a || fs_a) glitch++;
    end
    check_eq("rst_mid_inactive", 32'(glitch), 0);
    rst      = 1'b0;
    locked_a = 1'b1;
    hs_first = -1;
    vs_err   = 0;
    for (int k = 0; k < 2052; k++) begin
      tick();
      if (k == 0) begin
        check_eq("restart_fs",    32'(fs_a), 1);
        check_eq("restart_de",    32'(de_a), 1);
        check_eq("restart_pix_x", 32'(px_a), 0);
      end
      if (hs_a && hs_first < 0) hs_first = k;
      if (vs_a) vs_err++;
    end
    check_eq("restart_hsync_start", 32'(hs_first), 2008);
    check_eq("restart_vsync_high",  32'(vs_err), 0);

    // Small instance: two full frames (14 x 7 = 98 clks each)
    check_eq("small_unlocked_hsync", 32'(hs_b), 1);
    locked_b  = 1'b1;
    fs_n = 0; fs_first = -1; fs_second = -1;
    hsl_n = 0; hsl_first = -1; vsl_n = 0; vsl_first = -1;
    de_n = 0; max_x = 0; max_y = 0; vs_mid = 0; pix_err = 0;
    prev_vs = vs_b;
    for (int k = 0; k < 196; k++) begin
      tick();
      if (fs_b) begin
        fs_n++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (!hs_b) begin
        hsl_n++;
        if (hsl_first < 0) hsl_first = k;
      end
      if (!vs_b) begin
        vsl_n++;
        if (vsl_first < 0) vsl_first = k;
      end
      if (vs_b != prev_vs && (k % 14) != 0) vs_mid++;
      prev_vs = vs_b;
      if (de_b) begin
        de_n++;
        if (32'(px_b) > max_x) max_x = 32'(px_b);
        if (32'(py_b) > max_y) max_y = 32'(py_b);
      end else if (px_b != 12'd0 || py_b != 11'd0) begin
        pix_err++;
      end
    end
    check_eq("small_fs_count",    32'(fs_n), 2);
    check_eq("small_fs_first",    32'(fs_first), 0);
    check_eq("small_fs_period",   32'(fs_second), 98);
    check_eq("small_hsync_low_n", 32'(hsl_n), 28);
    check_eq("small_hsync_first", 32'(hsl_first), 10);
    check_eq("small_vsync_low_n", 32'(vsl_n), 28);
    check_eq("small_vsync_first", 32'(vsl_first), 70);
    check_eq("small_vsync_midln", 32'(vs_mid), 0);
    check_eq("small_de_count",    32'(de_n), 64);
    check_eq("small_max_x",       32'(max_x), 7);
    check_eq("small_max_y",       32'(max_y), 3);
    check_eq("small_pix_zero",    32'(pix_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
